// File: rtl/tt_sweep_reader.sv
// Truth-table sweep reader: drives every input vector of a small combinational network, samples its output.
// Optional onset counter enabled by defining TT_ONSET_COUNT_EN.
module tt_sweep_reader #(
   parameter int NUM_INPUTS = 6,
   parameter int SETTLE     = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         busy,
   output logic [NUM_INPUTS-1:0]        x_out,
   input  logic                         y_in,
   output logic [(1<<NUM_INPUTS)-1:0]   tt,
   output logic                         tt_valid,
   input  logic                         tt_ready
`ifdef TT_ONSET_COUNT_EN
   ,
   output logic [NUM_INPUTS:0]          onset_count
`endif
);

   localparam int                    TT_W       = 1 << NUM_INPUTS;
   localparam logic [7:0]            SETTLE_CNT = 8'(SETTLE);
   localparam logic [NUM_INPUTS-1:0] X_LAST     = '1;
   localparam logic [NUM_INPUTS-1:0] X_ONE      = NUM_INPUTS'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SWEEP,
      ST_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [NUM_INPUTS-1:0]   x_q, x_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [TT_W-1:0]         tt_q, tt_d;
`ifdef TT_ONSET_COUNT_EN
   localparam logic [NUM_INPUTS:0] ONSET_ONE = (NUM_INPUTS+1)'(1);
   logic [NUM_INPUTS:0]     onset_q, onset_d;
`endif

   // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned (no latch).
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      tt_d    = tt_q;
`ifdef TT_ONSET_COUNT_EN
      onset_d = onset_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SWEEP;
               x_d     = '0;
               cnt_d   = SETTLE_CNT;
               tt_d    = '0;
`ifdef TT_ONSET_COUNT_EN
               onset_d = '0;
`endif
            end
         end
         ST_SWEEP: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               tt_d[x_q] = y_in;
`ifdef TT_ONSET_COUNT_EN
               if (y_in) onset_d = onset_q + ONSET_ONE;
`endif
               // The index terminates at all-ones instead of rolling over to 0.
               if (x_q == X_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  x_d   = x_q + X_ONE;
                  cnt_d = SETTLE_CNT;
               end
            end
         end
         ST_DONE: begin
            if (tt_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         cnt_q   <= 8'd0;
         tt_q    <= '0;
`ifdef TT_ONSET_COUNT_EN
         onset_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         tt_q    <= tt_d;
`ifdef TT_ONSET_COUNT_EN
         onset_q <= onset_d;
`endif
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign tt_valid = (state_q == ST_DONE);
   assign x_out    = x_q;
   assign tt       = tt_q;
`ifdef TT_ONSET_COUNT_EN
   assign onset_count = onset_q;
`endif

endmodule

// File: tb/tb_tt_sweep_reader.sv
// Self-checking bench for tt_sweep_reader: three instances (SETTLE 2, 0, 3) with directed vector tables.
module tb_tt_sweep_reader;

   logic        clk;
   logic        rst;
   logic        start_v [3];
   logic        busy_v  [3];
   logic [5:0]  x_v     [3];
   logic        y_v     [3];
   logic [63:0] tt_v    [3];
   logic        valid_v [3];
   logic        ready_v [3];
`ifdef TT_ONSET_COUNT_EN
   logic [6:0]  onset_v [3];
`endif
   int          mode_v  [3];
   int          stab_v  [3];
   logic [5:0]  last_x  [3];

   int checks = 0;
   int errors = 0;

   tt_sweep_reader #(.NUM_INPUTS(6), .SETTLE(2)) u_s2 (
      .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .x_out(x_v[0]),
      .y_in(y_v[0]), .tt(tt_v[0]), .tt_valid(valid_v[0]), .tt_ready(ready_v[0])
`ifdef TT_ONSET_COUNT_EN
      , .onset_count(onset_v[0])
`endif
   );

   tt_sweep_reader #(.NUM_INPUTS(6), .SETTLE(0)) u_s0 (
      .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .x_out(x_v[1]),
      .y_in(y_v[1]), .tt(tt_v[1]), .tt_valid(valid_v[1]), .tt_ready(ready_v[1])
`ifdef TT_ONSET_COUNT_EN
      , .onset_count(onset_v[1])
`endif
   );

   tt_sweep_reader #(.NUM_INPUTS(6), .SETTLE(3)) u_s3 (
      .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .x_out(x_v[2]),
      .y_in(y_v[2]), .tt(tt_v[2]), .tt_valid(valid_v[2]), .tt_ready(ready_v[2])
`ifdef TT_ONSET_COUNT_EN
      , .onset_count(onset_v[2])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Network stimulus: mode selects the function; mode 7 only reads 1 once x has settled for 3 cycles.
   function automatic logic pat(input int mode, input logic [5:0] x, input int stab);
      case (mode)
         0: pat = 1'b0;
         1: pat = 1'b1;
         2: pat = x[0];
         3: pat = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
         4: pat = x[5];
         5: pat = &x;
         6: pat = ^x[2:0];
         7: pat = (stab >= 3);
         default: pat = 1'b0;
      endcase
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) y_v[i] = pat(mode_v[i], x_v[i], stab_v[i]);
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (x_v[i] !== last_x[i]) stab_v[i] <= 0;
         else if (stab_v[i] < 255) stab_v[i] <= stab_v[i] + 1;
         last_x[i] <= x_v[i];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_sweep(input int inst, input bit ready_early, input int hold, input bit poke,
                            output logic [63:0] tt_got, output int onset_got, output int lat);
      bit got;
      bit stable;
      logic [63:0] tt_cap;
      logic [5:0]  x_cap;
      ready_v[inst] = ready_early;
      @(negedge clk);
      start_v[inst] = 1'b1;
      @(posedge clk);
      #1 start_v[inst] = 1'b0;
      check("busy_after_start", 64'(busy_v[inst]), 64'd1);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 2000) begin
         start_v[inst] = poke && (lat == 4 || lat == 39);
         @(posedge clk);
         lat++;
         #1 start_v[inst] = 1'b0;
         got = valid_v[inst];
      end
      if (!got) check("valid_timeout", 64'd0, 64'd1);
      tt_got    = tt_v[inst];
      onset_got = 0;
`ifdef TT_ONSET_COUNT_EN
      onset_got = int'(onset_v[inst]);
`endif
      check("x_in_done", 64'(x_v[inst]), 64'd63);
      if (!ready_early) begin
         tt_cap = tt_v[inst];
         x_cap  = x_v[inst];
         stable = 1'b1;
         repeat (hold) begin
            @(posedge clk);
            #1;
            if (tt_v[inst] !== tt_cap || x_v[inst] !== x_cap || busy_v[inst] !== 1'b1 ||
                valid_v[inst] !== 1'b1) stable = 1'b0;
         end
         if (hold > 0) check("hold_stable", 64'(stable), 64'd1);
         @(negedge clk);
         ready_v[inst] = 1'b1;
         start_v[inst] = poke;
         @(posedge clk);
         #1;
         ready_v[inst] = 1'b0;
         start_v[inst] = 1'b0;
      end else begin
         @(posedge clk);
         #1;
      end
      check("busy_after_hs", 64'(busy_v[inst]), 64'd0);
      check("valid_after_hs", 64'(valid_v[inst]), 64'd0);
      if (poke) begin
         @(posedge clk);
         #1 check("hs_start_ignored", 64'(busy_v[inst]), 64'd0);
      end
   endtask

   typedef struct {
      string       name;
      int          mode;
      int          hold;
      bit          poke;
      logic [63:0] exp_tt;
      int          exp_onset;
   } vec_t;

   vec_t vecs [7];

   initial begin
      logic [63:0] tt_got;
      int onset_got;
      int lat;
      int n;

      vecs[0] = '{"zero",   0, 20, 1'b1, 64'h0000_0000_0000_0000, 0};
      vecs[1] = '{"one",    1,  2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64};
      vecs[2] = '{"x0",     2,  2, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 32};
      vecs[3] = '{"maj",    3,  0, 1'b0, 64'hE8E8_E8E8_E8E8_E8E8, 32};
      vecs[4] = '{"x5",     4,  1, 1'b0, 64'hFFFF_FFFF_0000_0000, 32};
      vecs[5] = '{"and6",   5,  1, 1'b0, 64'h8000_0000_0000_0000, 1};
      vecs[6] = '{"par3",   6,  1, 1'b0, 64'h9696_9696_9696_9696, 32};

      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         ready_v[i] = 1'b0;
         mode_v[i]  = 0;
      end
      mode_v[1] = 3;
      mode_v[2] = 7;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("rst_busy",  64'(busy_v[i]),  64'd0);
         check("rst_valid", 64'(valid_v[i]), 64'd0);
         check("rst_x",     64'(x_v[i]),     64'd0);
         check("rst_tt",    tt_v[i],         64'd0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         mode_v[0] = vecs[v].mode;
         run_sweep(0, 1'b0, vecs[v].hold, vecs[v].poke, tt_got, onset_got, lat);
         check({vecs[v].name, "_tt"}, tt_got, vecs[v].exp_tt);
         check({vecs[v].name, "_lat"}, 64'(lat), 64'd192);
`ifdef TT_ONSET_COUNT_EN
         check({vecs[v].name, "_onset"}, 64'(onset_got), 64'(vecs[v].exp_onset));
`endif
      end

      run_sweep(1, 1'b1, 0, 1'b0, tt_got, onset_got, lat);
      check("s0_maj_tt", tt_got, 64'hE8E8_E8E8_E8E8_E8E8);
      check("s0_lat", 64'(lat), 64'd64);
`ifdef TT_ONSET_COUNT_EN
      check("s0_onset", 64'(onset_got), 64'd32);
`endif

      run_sweep(2, 1'b0, 0, 1'b0, tt_got, onset_got, lat);
      check("s3_settle_tt", tt_got, 64'hFFFF_FFFF_FFFF_FFFF);
      check("s3_lat", 64'(lat), 64'd256);
`ifdef TT_ONSET_COUNT_EN
      check("s3_onset", 64'(onset_got), 64'd64);
`endif

      // Abort a sweep part-way through with an asynchronous reset.
      mode_v[0] = 1;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1 start_v[0] = 1'b0;
      n = 0;
      while (x_v[0] !== 6'd17 && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("reach_x17", 64'(x_v[0]), 64'd17);
      check("partial_tt_nonzero", 64'(tt_v[0] != 64'd0), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("abort_busy",  64'(busy_v[0]),  64'd0);
      check("abort_valid", 64'(valid_v[0]), 64'd0);
      check("abort_x",     64'(x_v[0]),     64'd0);
      check("abort_tt",    tt_v[0],         64'd0);
`ifdef TT_ONSET_COUNT_EN
      check("abort_onset", 64'(onset_v[0]), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      mode_v[0] = 3;
      run_sweep(0, 1'b0, 1, 1'b0, tt_got, onset_got, lat);
      check("post_abort_tt", tt_got, 64'hE8E8_E8E8_E8E8_E8E8);
      check("post_abort_lat", 64'(lat), 64'd192);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tt_sweep_reader.md
# tt_sweep_reader

Sequential characterisation block for the 6-input, single-output combinational networks produced by the synthesis flow. It drives every input vector onto the network under test in ascending order. After a programmable settle time it samples the single output and assembles the complete truth table. The table is delivered over a valid/ready handshake. It sits on the bench/FPGA side of a generated netlist: the network consumes the vector, and this block reads back its answer.

## Interface
Parameters:
- `NUM_INPUTS`, default 6: number of network inputs. The table width is 2^NUM_INPUTS.
- `SETTLE`, default 2: idle cycles between driving a vector and sampling the network output. Legal range is 0 to 255.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: requests a sweep. Accepted only in IDLE.
- `busy`, output, 1: high from start acceptance until the table is consumed.
- `x_out`, output, NUM_INPUTS: vector driven to the network under test.
- `y_in`, input, 1: network output. Must be stable SETTLE cycles after `x_out` changes.
- `tt`, output, 2^NUM_INPUTS: truth table. Bit i equals `y_in` observed while `x_out == i`.
- `tt_valid`, output, 1: table available.
- `tt_ready`, input, 1: consumer accepts the table.
- `onset_count`, output, NUM_INPUTS+1: number of 1 bits in `tt`. Present only with `TT_ONSET_COUNT_EN`.

## Operation
- FSM has three states: IDLE, SWEEP and DONE.
- Registers:
  - vector index `x_out` (NUM_INPUTS bits)
  - settle counter `cnt`, 8 bits
  - shift-free table register `tt`, written bit-addressed
- IDLE:
  - `busy=0`, `tt_valid=0`.
  - On `start=1`: go to SWEEP, `x_out<=0`, `cnt<=SETTLE`, `tt<=0`, `onset_count<=0`.
- SWEEP:
  - If `cnt!=0`: `cnt<=cnt-1`.
  - If `cnt==0`: `tt[x_out]<=y_in`. The onset counter increments when `y_in=1`.
  - On that same `cnt==0` cycle, if `x_out` equals all-ones, go to DONE and `x_out` holds its value. Otherwise `x_out<=x_out+1` and `cnt<=SETTLE`.
- DONE:
  - `tt_valid=1`. `tt`, `x_out` and `onset_count` are held stable.
  - On `tt_valid & tt_ready`: go to IDLE in the same cycle.
- `start` is ignored in SWEEP and DONE. A start pulse asserted in the cycle of the DONE→IDLE transition is also ignored, because the state is not yet IDLE.
- `x_out` wraps only by terminating. The index never rolls from all-ones to 0 within a sweep.
- Arithmetic:
  - Index and count increments are unsigned.
  - The onset counter cannot overflow: its maximum is 2^NUM_INPUTS, which fits in NUM_INPUTS+1 bits.
- `y_in` is sampled directly on the edge, with no synchronizer, because the network is on `clk`'s domain.

## Timing
- Reset values:
  - state IDLE
  - `busy=0`, `tt_valid=0`
  - `x_out=0`, `tt=0`, `onset_count=0`, `cnt=0`
- Reset mid-sweep or in DONE aborts immediately to the reset values. No partial table is ever flagged valid.
- Per-vector period is SETTLE+1 cycles.
- Start acceptance edge is edge k:
  - The first sample occurs at edge k+SETTLE+1.
  - The last sample occurs at edge k+2^NUM_INPUTS·(SETTLE+1).
  - `tt_valid` is high from that edge on.
- With default parameters (6 inputs, SETTLE=2), `tt_valid` rises 192 cycles after start acceptance.
- `busy` is high from edge k through the handshake edge, inclusive of the DONE cycles.
- Minimum DONE residence is 1 cycle, when `tt_ready` is already high.
- A new sweep can be accepted no earlier than 1 cycle after the handshake.

## Configuration
- `TT_ONSET_COUNT_EN` defined:
  - `onset_count` port and counter are present.
  - The counter is cleared at start and updated at each sample.
  - It is valid and stable whenever `tt_valid=1`.
- `TT_ONSET_COUNT_EN` undefined:
  - Port and counter are omitted.
  - All other behaviour and timing are identical.

## Test plan
- **MAJ sweep:** `y_in` driven as MAJ(x0,x1,x2) of `x_out`, SETTLE=0, `tt_ready=1` → `tt=64'hE8E8E8E8E8E8E8E8`, `onset_count=32`. `tt_valid` rises 64 cycles after start.
- **Settle timing:** SETTLE=3, `y_in` forced high only when `x_out` has been stable ≥3 cycles (model glitches as 0 otherwise) → `tt` all ones, `onset_count=64`. `tt_valid` rises at cycle 256.
- **Backpressure:** `tt_ready=0` for 20 cycles after `tt_valid` → `tt`, `x_out`, `busy` and `tt_valid` stay constant. Raising `tt_ready` for 1 cycle returns to IDLE with `busy=0` next cycle.
- **Start ignored:** `start` pulsed at cycles 5, 40 and on the handshake cycle → only the first pulse launches a sweep. The handshake-cycle pulse launches nothing.
- **Reset mid-sweep:** `rst` asserted asynchronously with `x_out=17` → all outputs at reset values immediately. A fresh start then produces the correct full table.
- **Constant zero:** `y_in=0`, default parameters → `tt=0`, `onset_count=0`. `tt_valid` rises at cycle 192.
